xnor_popcount_acc: RTL and testbench

Streaming, parametrised XNOR-popcount accumulator. It is the pipelined successor of the fixed 128-bit combinational popcount mimic circuit. Each beat carries VEC_W bit pairs plus a per-bit mask; popcounts are accumulated across beats until in_last, then one dot-product result is emitted with valid/ready. It sits between the binarised activation/weight streamers and the threshold/activation unit of the BNN datapath.

---
 rtl/popcnt_pkg.sv | 20 ++
 rtl/xnor_popcount_tree.sv | 58 +++++
 rtl/xnor_popcount_acc.sv | 142 ++++++++++++++
 tb/tb_xnor_popcount_acc.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcnt_pkg.sv
// Shared sizing helpers and the bipolar conversion used by the XNOR-popcount
// accumulator and its popcount trees.
package popcnt_pkg;

    localparam int CHUNK_W_DEFAULT = 20;

    function automatic int pop_width(input int vec_w);
        return $clog2(vec_w + 1);
    endfunction

    function automatic int acc_width(input int vec_w, input int max_beats);
        return $clog2(vec_w * max_beats + 1);
    endfunction

    // Map a {+1,-1} match count onto the signed dot product: 2*sum - nbits.
    function automatic int bipolar(input int sum, input int nbits);
        return 2 * sum - nbits;
    endfunction

endpackage

// File: rtl/xnor_popcount_tree.sv
// Combinational masked-XNOR popcount: per-chunk two-level counts feeding a
// balanced pairwise adder tree.
module xnor_popcount_tree
    import popcnt_pkg::*;
#(
    parameter int VEC_W = 128,
    parameter int CHUNK_W = CHUNK_W_DEFAULT,
    localparam int POP_W = pop_width(VEC_W)
) (
    input  logic [VEC_W-1:0] x,
    input  logic [VEC_W-1:0] y,
    input  logic [VEC_W-1:0] mask,
    output logic [POP_W-1:0] count
);

    localparam int N_CHUNK = (VEC_W + CHUNK_W - 1) / CHUNK_W;
    localparam int N_LEAF  = 1 << $clog2(N_CHUNK);

    logic [VEC_W-1:0] match;
    logic [POP_W-1:0] part [N_LEAF];

    assign match = ~(x ^ y) & mask;

    genvar c;
    for (c = 0; c < N_LEAF; c++) begin : g_leaf
        if (c < N_CHUNK) begin : g_chunk
            localparam int LO   = c * CHUNK_W;
            localparam int LEN  = (VEC_W - LO < CHUNK_W) ? VEC_W - LO : CHUNK_W;
            localparam int HALF = LEN / 2;
            logic [POP_W-1:0] lo_cnt;
            logic [POP_W-1:0] hi_cnt;
            always_comb begin
                lo_cnt = '0;
                hi_cnt = '0;
                for (int i = 0; i < HALF; i++)
                    lo_cnt = lo_cnt + POP_W'(match[LO+i]);
                for (int i = HALF; i < LEN; i++)
                    hi_cnt = hi_cnt + POP_W'(match[LO+i]);
            end
            assign part[c] = lo_cnt + hi_cnt;
        end else begin : g_pad
            assign part[c] = '0;
        end
    end

    // In-place pairwise reduction: slot i only reads slots 2i and 2i+1, which
    // have not yet been overwritten at that width.
    always_comb begin
        logic [POP_W-1:0] lvl [N_LEAF];
        for (int i = 0; i < N_LEAF; i++)
            lvl[i] = part[i];
        for (int w = N_LEAF / 2; w >= 1; w = w / 2)
            for (int i = 0; i < w; i++)
                lvl[i] = lvl[2*i] + lvl[2*i+1];
        count = lvl[0];
    end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Streaming XNOR-popcount accumulator: one popcount register stage, one
// accumulate stage, and a held output register with valid/ready.
module xnor_popcount_acc
    import popcnt_pkg::*;
#(
    parameter int VEC_W = 128,
    parameter int CHUNK_W = CHUNK_W_DEFAULT,
    parameter int MAX_BEATS = 16,
    localparam int POP_W = pop_width(VEC_W),
    localparam int ACC_W = acc_width(VEC_W, MAX_BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_x,
    input  logic [VEC_W-1:0] in_y,
    input  logic [VEC_W-1:0] in_mask,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [ACC_W-1:0] out_nbits,
    output logic [ACC_W:0]   out_dot,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

    logic [POP_W-1:0] pop_p0;
    logic [POP_W-1:0] nb_p0;

    logic             vld_p1;
    logic             last_p1;
    logic [POP_W-1:0] pop_p1;
    logic [POP_W-1:0] nb_p1;

    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_nb;
    logic [CNT_W-1:0] beat_cnt;
    logic             ovf_pend;

    logic                    s2_take;
    logic                    s1_adv;
    logic [ACC_W:0]          sum_wide;
    logic [ACC_W:0]          nb_wide;
    logic [ACC_W-1:0]        sum_next;
    logic [ACC_W-1:0]        nb_next;
    logic                    ovf_next;
    logic signed [ACC_W:0]   dot_next;

    xnor_popcount_tree #(.VEC_W(VEC_W), .CHUNK_W(CHUNK_W)) u_match (
        .x     (in_x),
        .y     (in_y),
        .mask  (in_mask),
        .count (pop_p0)
    );

    xnor_popcount_tree #(.VEC_W(VEC_W), .CHUNK_W(CHUNK_W)) u_nbits (
        .x     (in_mask),
        .y     (in_mask),
        .mask  (in_mask),
        .count (nb_p0)
    );

    assign s2_take  = !last_p1 || !out_valid || out_ready;
    assign in_ready = !vld_p1 || s2_take;
    assign s1_adv   = vld_p1 && s2_take;

    // ---- stage 1: popcount register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid)
                last_p1 <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            pop_p1 <= pop_p0;
            nb_p1  <= nb_p0;
        end
    end

    // ---- stage 2: accumulate ----
    // Once a product runs past MAX_BEATS both sums are pegged at all-ones.
    always_comb begin
        sum_wide = {1'b0, acc_sum} + (ACC_W+1)'(pop_p1);
        nb_wide  = {1'b0, acc_nb} + (ACC_W+1)'(nb_p1);
        ovf_next = ovf_pend || (beat_cnt >= CNT_MAX);
        sum_next = (ovf_next || sum_wide[ACC_W]) ? '1 : sum_wide[ACC_W-1:0];
        nb_next  = (ovf_next || nb_wide[ACC_W]) ? '1 : nb_wide[ACC_W-1:0];
        dot_next = (ACC_W+1)'(bipolar(int'(sum_next), int'(nb_next)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum  <= '0;
            acc_nb   <= '0;
            beat_cnt <= '0;
            ovf_pend <= 1'b0;
        end else if (s1_adv) begin
            if (last_p1) begin
                acc_sum  <= '0;
                acc_nb   <= '0;
                beat_cnt <= '0;
                ovf_pend <= 1'b0;
            end else begin
                acc_sum  <= sum_next;
                acc_nb   <= nb_next;
                beat_cnt <= (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + CNT_W'(1);
                ovf_pend <= ovf_next;
            end
        end
    end

    // ---- output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_nbits <= '0;
            out_dot   <= '0;
            out_ovf   <= 1'b0;
        end else if (s1_adv && last_p1) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_nbits <= nb_next;
            out_dot   <= dot_next;
            out_ovf   <= ovf_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Randomised bench for xnor_popcount_acc with a transaction-level model of
// each dot product.
module tb_xnor_popcount_acc;

    localparam int VEC_W = 128;
    localparam int MAX_BEATS = 4;
    localparam int ACC_W = $clog2(VEC_W * MAX_BEATS + 1);
    localparam int SAT = (1 << ACC_W) - 1;

    typedef struct packed {
        logic [VEC_W-1:0] x;
        logic [VEC_W-1:0] y;
        logic [VEC_W-1:0] m;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [ACC_W-1:0] nb;
        logic [ACC_W:0]   dot;
        logic             ovf;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_x;
    logic [VEC_W-1:0] in_y;
    logic [VEC_W-1:0] in_mask;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [ACC_W-1:0] out_nbits;
    logic [ACC_W:0]   out_dot;
    logic             out_ovf;

    int    vectors = 0;
    int    miscompares = 0;
    int    stall_cnt = 0;
    bit    hold_ready = 0;
    beat_t beat_q[$];
    res_t  exp_q[$];
    res_t  got_q[$];

    xnor_popcount_acc #(.VEC_W(VEC_W), .CHUNK_W(20), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_nbits (out_nbits),
        .out_dot   (out_dot),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        #4;
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_sum, out_nbits, out_dot, out_ovf});
        if (in_valid && !in_ready)
            stall_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [VEC_W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // kind 0: random, 1: all bits match with full mask, 2: all bits differ with full mask
    task automatic add_product(input int n, input int kind);
        int s = 0;
        int nb = 0;
        beat_t b;
        res_t r;
        for (int i = 0; i < n; i++) begin
            b.x = rand128();
            case (kind)
                1: begin b.y = b.x; b.m = '1; end
                2: begin b.y = ~b.x; b.m = '1; end
                default: begin
                    b.y = b.x ^ (rand128() & rand128());
                    b.m = ($urandom_range(7) == 0) ? '0 : (rand128() | rand128());
                end
            endcase
            b.last = (i == n - 1);
            s  += $countones(~(b.x ^ b.y) & b.m);
            nb += $countones(b.m);
            beat_q.push_back(b);
        end
        if (n > MAX_BEATS) begin
            s  = SAT;
            nb = SAT;
        end
        r.sum = ACC_W'(s);
        r.nb  = ACC_W'(nb);
        r.dot = (ACC_W+1)'(2 * s - nb);
        r.ovf = (n > MAX_BEATS);
        exp_q.push_back(r);
    endtask

    task automatic clear_queues();
        beat_q.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_stream(input int vprob, input int rprob, input int max_cyc);
        int cyc = 0;
        bit pend = 0;
        while ((beat_q.size() != 0 || got_q.size() < exp_q.size()) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            out_ready = !hold_ready && ($urandom_range(99) < rprob);
            if (beat_q.size() != 0 && (pend || $urandom_range(99) < vprob)) begin
                in_valid = 1'b1;
                in_x     = beat_q[0].x;
                in_y     = beat_q[0].y;
                in_mask  = beat_q[0].m;
                in_last  = beat_q[0].last;
                pend     = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_x     = rand128();
                in_y     = rand128();
                in_mask  = rand128();
                in_last  = $urandom_range(1);
            end
            #4;
            if (in_valid && in_ready) begin
                void'(beat_q.pop_front());
                pend = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (beat_q.size() != 0 || got_q.size() < exp_q.size()) begin
            miscompares++;
            $display("FAIL stream_timeout beats_left=%0d results=%0d expected=%0d",
                     beat_q.size(), got_q.size(), exp_q.size());
        end
    endtask

    task automatic drive_beat(input beat_t b);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = b.x;
        in_y     = b.y;
        in_mask  = b.m;
        in_last  = b.last;
        #4;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #4;
            w++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, out_sum, out_nbits, out_dot, out_ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got valid=%0b sum=%0d nb=%0d dot=%0d ovf=%0b required all 0",
                     out_valid, out_sum, out_nbits, out_dot, out_ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        beat_t b;
        res_t  exp[2];
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            b.x = (t == 0) ? {VEC_W{1'b1}} : rand128();
            b.y = (t == 0) ? b.x : ~b.x;
            b.m = (t == 0) ? {VEC_W{1'b1}} : {{(VEC_W/2){1'b0}}, {(VEC_W/2){1'b1}}};
            b.last = 1'b1;
            exp[0] = {ACC_W'(128), ACC_W'(128), (ACC_W+1)'(128), 1'b0};
            exp[1] = {ACC_W'(0), ACC_W'(64), (ACC_W+1)'(-64), 1'b0};
            drive_beat(b);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single%0d_early_valid got=%0b required=0", t, out_valid);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, out_sum, out_nbits, out_dot, out_ovf} !== {1'b1, exp[t]}) begin
                miscompares++;
                $display("FAIL single%0d_result got valid=%0b sum=%0d nb=%0d dot=%0d ovf=%0b required sum=%0d nb=%0d dot=%0d",
                         t, out_valid, out_sum, out_nbits, $signed(out_dot), out_ovf,
                         exp[t].sum, exp[t].nb, $signed(exp[t].dot));
            end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        add_product(3, 1);
        add_product(1, 2);
        add_product(2, 0);
        stall_cnt = 0;
        run_stream(100, 100, 100);
        vectors++;
        if (stall_cnt !== 0) begin
            miscompares++;
            $display("FAIL b2b_bubbles got=%0d required=0", stall_cnt);
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_result[%0d] got sum=%0d nb=%0d dot=%0d ovf=%0b required sum=%0d nb=%0d dot=%0d ovf=%0b",
                         i, got_q[i].sum, got_q[i].nb, $signed(got_q[i].dot), got_q[i].ovf,
                         exp_q[i].sum, exp_q[i].nb, $signed(exp_q[i].dot), exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_overflow();
        clear_queues();
        add_product(6, 1);
        add_product(2, 0);
        add_product(MAX_BEATS, 1);
        run_stream(100, 100, 100);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL ovf_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ovf_result[%0d] got sum=%0d nb=%0d dot=%0d ovf=%0b required sum=%0d nb=%0d dot=%0d ovf=%0b",
                         i, got_q[i].sum, got_q[i].nb, $signed(got_q[i].dot), got_q[i].ovf,
                         exp_q[i].sum, exp_q[i].nb, $signed(exp_q[i].dot), exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        add_product(2, 0);
        add_product(2, 0);
        add_product(2, 0);
        hold_ready = 1'b1;
        fork
            run_stream(100, 100, 400);
            begin
                int   w = 0;
                bit   saw_block = 0;
                res_t snap;
                while (!out_valid && w < 50) begin
                    @(negedge clk);
                    #4;
                    w++;
                end
                vectors++;
                if (out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_first_valid got=%0b required=1", out_valid);
                end
                snap = {out_sum, out_nbits, out_dot, out_ovf};
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #4;
                    vectors++;
                    if ({out_valid, out_sum, out_nbits, out_dot, out_ovf} !== {1'b1, snap}) begin
                        miscompares++;
                        $display("FAIL bp_hold[%0d] got valid=%0b sum=%0d nb=%0d required valid=1 sum=%0d nb=%0d",
                                 k, out_valid, out_sum, out_nbits, snap.sum, snap.nb);
                    end
                    if (!in_ready)
                        saw_block = 1'b1;
                end
                vectors++;
                if (saw_block !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_in_ready_drop got=%0b required=1", saw_block);
                end
                hold_ready = 1'b0;
            end
        join
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_result[%0d] got sum=%0d nb=%0d dot=%0d required sum=%0d nb=%0d dot=%0d",
                         i, got_q[i].sum, got_q[i].nb, $signed(got_q[i].dot),
                         exp_q[i].sum, exp_q[i].nb, $signed(exp_q[i].dot));
            end
        end
    endtask

    task automatic test_random();
        clear_queues();
        for (int p = 0; p < 30; p++)
            add_product($urandom_range(1, 6), ($urandom_range(5) == 0) ? $urandom_range(1, 2) : 0);
        run_stream(70, 60, 5000);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_result[%0d] got sum=%0d nb=%0d dot=%0d ovf=%0b required sum=%0d nb=%0d dot=%0d ovf=%0b",
                         i, got_q[i].sum, got_q[i].nb, $signed(got_q[i].dot), got_q[i].ovf,
                         exp_q[i].sum, exp_q[i].nb, $signed(exp_q[i].dot), exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        clear_queues();
        out_ready = 1'b0;
        b.x = rand128();
        b.y = b.x;
        b.m = '1;
        b.last = 1'b1;
        drive_beat(b);
        for (int i = 0; i < 2; i++) begin
            b.x = rand128();
            b.y = rand128();
            b.m = '1;
            b.last = 1'b0;
            drive_beat(b);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_held_valid got=%0b required=1", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_sum, out_nbits, out_dot, out_ovf} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs got valid=%0b sum=%0d nb=%0d dot=%0d ovf=%0b required all 0",
                     out_valid, out_sum, out_nbits, out_dot, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        add_product(1, 0);
        run_stream(100, 100, 50);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL rstmid_next got n=%0d sum=%0d nb=%0d required n=1 sum=%0d nb=%0d",
                     got_q.size(), (got_q.size() != 0) ? got_q[0].sum : 0,
                     (got_q.size() != 0) ? got_q[0].nb : 0, exp_q[0].sum, exp_q[0].nb);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
